// File: rtl/half_adder_pkg.sv
// Shared types and constants for the registered lane-parallel half adder.
package half_adder_pkg;

  localparam int HA_WIDTH_DEFAULT = 1;
  localparam int HA_CNT_W         = 32;

  typedef struct packed {
    logic s;
    logic c;
  } ha_lane_t;

  // Single-lane half-adder result; s and c can never both be set.
  function automatic ha_lane_t ha_eval(input logic a, input logic b);
    ha_lane_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Purely combinational single-lane half adder.
module half_adder_bit
  import half_adder_pkg::*;
(
  input  logic     x,
  input  logic     y,
  output ha_lane_t lane
);

  assign lane = ha_eval(x, y);

endmodule

// File: rtl/half_adder_unit.sv
// Registered lane-parallel half adder with one-cycle latency.
// Optional popcount-of-carries counter enabled by HALF_ADDER_UNIT_CARRY_CNT_EN.
module half_adder_unit
  import half_adder_pkg::*;
#(
  parameter int   WIDTH   = HA_WIDTH_DEFAULT,
  parameter logic RESET_S = 1'b0,
  parameter logic RESET_C = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    x,
  input  logic [WIDTH-1:0]    y,
`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
  input  logic                cnt_clr,
  output logic [HA_CNT_W-1:0] carry_cnt,
`endif
  output logic                out_valid,
  output logic [WIDTH-1:0]    s,
  output logic [WIDTH-1:0]    c
);

  ha_lane_t         lane_s [WIDTH];
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] c_r;
  logic             out_valid_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_bit u_bit (
      .x    (x[i]),
      .y    (y[i]),
      .lane (lane_s[i])
    );
  end

  // Unpack lane structs into flat sum and carry vectors
  always_comb begin
    sum_s   = '0;
    carry_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_s[i]   = lane_s[i].s;
      carry_s[i] = lane_s[i].c;
    end
  end

  // Result register: capture on in_valid, hold data otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r         <= {WIDTH{RESET_S}};
      c_r         <= {WIDTH{RESET_C}};
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      s_r         <= sum_s;
      c_r         <= carry_s;
      out_valid_r <= 1'b1;
    end else begin
      s_r         <= s_r;
      c_r         <= c_r;
      out_valid_r <= 1'b0;
    end
  end

  assign s         = s_r;
  assign c         = c_r;
  assign out_valid = out_valid_r;

`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
  logic [HA_CNT_W-1:0] pop_s;
  logic [HA_CNT_W-1:0] cnt_r;

  // Number of lanes producing a carry this cycle
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_s = pop_s + HA_CNT_W'(carry_s[i]);
    end
  end

  // Carry counter: clear beats increment, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (in_valid) begin
      cnt_r <= cnt_r + pop_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign carry_cnt = cnt_r;
`else
  // Counter absent: s, c and out_valid are unaffected.
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed, table-driven bench for half_adder_unit at WIDTH=1 and WIDTH=8.
module tb_half_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] s8, c8;
  logic       v8;
  logic [0:0] s1, c1;
  logic       v1;
  int         n_vec = 0;
  int         n_err = 0;

`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
  logic        cnt_clr;
  logic [31:0] cnt8, cnt1;
`endif

  always #5 clk = ~clk;

  half_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
    .cnt_clr   (cnt_clr),
    .carry_cnt (cnt8),
`endif
    .out_valid (v8),
    .s         (s8),
    .c         (c8)
  );

  half_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x[0:0]),
    .y         (y[0:0]),
`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
    .cnt_clr   (cnt_clr),
    .carry_cnt (cnt1),
`endif
    .out_valid (v1),
    .s         (s1),
    .c         (c1)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       v;
    logic [7:0] es;
    logic [7:0] ec;
    logic       ev;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [7:0] es, input logic [7:0] ec, input logic ev);
    check("s8", 32'(s8), 32'(es));
    check("c8", 32'(c8), 32'(ec));
    check("v8", 32'(v8), 32'(ev));
    check("s1", 32'(s1), 32'(es[0]));
    check("c1", 32'(c1), 32'(ec[0]));
    check("v1", 32'(v1), 32'(ev));
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[1] = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8'h01, 1'b1, 8'h01, 8'h00, 1'b1};
    tbl[3] = '{8'h01, 8'h01, 1'b1, 8'h00, 8'h01, 1'b1};
    tbl[4] = '{8'hF0, 8'hCC, 1'b1, 8'h3C, 8'hC0, 1'b1};
    tbl[5] = '{8'hA5, 8'h0F, 1'b1, 8'hAA, 8'h05, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 1'b0, 8'hAA, 8'h05, 1'b0};
    tbl[7] = '{8'h55, 8'hAA, 1'b1, 8'hFF, 8'h00, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = 8'hFF;
    y        = 8'hFF;
`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
    cnt_clr  = 1'b0;
`endif

    // Reset held with clock running and valid 11 on the inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all(8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      x        = tbl[i].x;
      y        = tbl[i].y;
      in_valid = tbl[i].v;
      @(posedge clk);
      #1;
      check_all(tbl[i].es, tbl[i].ec, tbl[i].ev);
    end

    // Hold: valid 10, then invalid 11 must not disturb s/c
    x = 8'h01; y = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    check_all(8'h01, 8'h00, 1'b1);
    x = 8'hFF; y = 8'hFF; in_valid = 1'b0;
    @(posedge clk); #1;
    check_all(8'h01, 8'h00, 1'b0);
    @(posedge clk); #1;
    check_all(8'h01, 8'h00, 1'b0);

    // Async reset between edges after a valid 11
    x = 8'hFF; y = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    check_all(8'h00, 8'hFF, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all(8'h00, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(8'h00, 8'h00, 1'b0);

`ifdef HALF_ADDER_UNIT_CARRY_CNT_EN
    check("cnt_rst", cnt8, 32'd0);
    x = 8'hFF; y = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    check("cnt_1", cnt8, 32'd8);
    check("cnt1_1", cnt1, 32'd1);
    @(posedge clk); #1;
    check("cnt_2", cnt8, 32'd16);
    check("cnt1_2", cnt1, 32'd2);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("cnt_clr", cnt8, 32'd0);
    check("cnt1_clr", cnt1, 32'd0);
    cnt_clr = 1'b0;
    x = 8'h0F; y = 8'h03;
    @(posedge clk); #1;
    check("cnt_pop", cnt8, 32'd2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("cnt_hold", cnt8, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
